// File: rtl/bus_arbiter.sv
// Round-robin arbiter/sequencer for the shared snooping coherence bus.
// Grants one cache, broadcasts its command/address once, then holds the bus until completion or watchdog expiry.
module bus_arbiter #(
   parameter int NUM_CACHES = 4,
   parameter int XLEN       = 32,
   parameter int TIMEOUT    = 64
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [NUM_CACHES-1:0]           req,
   input  logic [2*NUM_CACHES-1:0]         req_cmd,
   input  logic [XLEN*NUM_CACHES-1:0]      req_addr,
   input  logic                            bus_done,
   output logic [NUM_CACHES-1:0]           gnt,
   output logic                            bus_valid,
   output logic [1:0]                      bus_cmd,
   output logic [XLEN-1:0]                 bus_addr,
   output logic [$clog2(NUM_CACHES)-1:0]   bus_owner,
   output logic                            timeout_err
);

   localparam int OW = $clog2(NUM_CACHES);
   localparam int WW = $clog2(TIMEOUT);

   localparam logic [1:0]            CMD_BUSRD  = 2'd0;
   localparam logic [1:0]            CMD_BUSRDX = 2'd1;
   localparam logic [1:0]            CMD_RSVD   = 2'd3;
   localparam logic [OW:0]           NC         = (OW+1)'(NUM_CACHES);
   localparam logic [OW-1:0]         OWN_LAST   = OW'(NUM_CACHES-1);
   localparam logic [WW-1:0]         WCNT_MAX   = WW'(TIMEOUT-1);
   localparam logic [NUM_CACHES-1:0] GNT_ONE    = NUM_CACHES'(1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_BCAST,
      S_WAIT,
      S_RELEASE
   } state_t;

   state_t                r_state;
   logic [OW-1:0]         r_ptr;
   logic [WW-1:0]         r_wcnt;
   logic [NUM_CACHES-1:0] r_gnt;
   logic                  r_valid;
   logic [1:0]            r_cmd;
   logic [XLEN-1:0]       r_addr;
   logic [OW-1:0]         r_owner;
   logic                  r_terr;

   logic                  w_found;
   logic [OW-1:0]         w_sel;
   logic [OW:0]           w_idx;
   logic [1:0]            w_cmd_arr  [NUM_CACHES];
   logic [XLEN-1:0]       w_addr_arr [NUM_CACHES];

   for (genvar g = 0; g < NUM_CACHES; g++) begin : g_unpack
      assign w_cmd_arr[g]  = req_cmd[2*g +: 2];
      assign w_addr_arr[g] = req_addr[XLEN*g +: XLEN];
   end

   // First requester at or above r_ptr, wrapping; index kept one bit wide to absorb the wrap.
   always_comb begin
      w_found = 1'b0;
      w_sel   = '0;
      w_idx   = '0;
      for (int unsigned i = 0; i < NUM_CACHES; i++) begin
         w_idx = {1'b0, r_ptr} + (OW+1)'(i);
         if (w_idx >= NC) begin
            w_idx = w_idx - NC;
         end
         if (!w_found && req[w_idx[OW-1:0]]) begin
            w_found = 1'b1;
            w_sel   = w_idx[OW-1:0];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_ptr   <= '0;
         r_wcnt  <= '0;
         r_gnt   <= '0;
         r_valid <= 1'b0;
         r_cmd   <= '0;
         r_addr  <= '0;
         r_owner <= '0;
         r_terr  <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_found) begin
                  r_owner <= w_sel;
                  r_cmd   <= w_cmd_arr[w_sel];
                  r_addr  <= w_addr_arr[w_sel];
                  r_gnt   <= GNT_ONE << w_sel;
                  r_valid <= (w_cmd_arr[w_sel] != CMD_RSVD);
                  r_state <= S_BCAST;
               end
            end
            S_BCAST: begin
               r_valid <= 1'b0;
               if (r_cmd == CMD_BUSRD || r_cmd == CMD_BUSRDX) begin
                  r_wcnt  <= '0;
                  r_state <= S_WAIT;
               end else begin
                  r_gnt   <= '0;
                  r_state <= S_RELEASE;
               end
            end
            S_WAIT: begin
               // Completion takes precedence over a simultaneous watchdog expiry.
               if (bus_done) begin
                  r_gnt   <= '0;
                  r_state <= S_RELEASE;
               end else if (r_wcnt == WCNT_MAX) begin
                  r_terr  <= 1'b1;
                  r_gnt   <= '0;
                  r_state <= S_RELEASE;
               end else begin
                  r_wcnt <= r_wcnt + 1'b1;
               end
            end
            S_RELEASE: begin
               r_ptr   <= (r_owner == OWN_LAST) ? '0 : r_owner + 1'b1;
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign gnt         = r_gnt;
   assign bus_valid   = r_valid;
   assign bus_cmd     = r_cmd;
   assign bus_addr    = r_addr;
   assign bus_owner   = r_owner;
   assign timeout_err = r_terr;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed and randomized bench for bus_arbiter against a transaction-level round-robin model.
module tb_bus_arbiter;

   localparam int N  = 4;
   localparam int XL = 32;
   localparam int TO = 8;

   logic              clk = 1'b0;
   logic              rst;
   logic [N-1:0]      req;
   logic [2*N-1:0]    req_cmd;
   logic [XL*N-1:0]   req_addr;
   logic              bus_done;
   logic [N-1:0]      gnt;
   logic              bus_valid;
   logic [1:0]        bus_cmd;
   logic [XL-1:0]     bus_addr;
   logic [1:0]        bus_owner;
   logic              timeout_err;

   bus_arbiter #(
      .NUM_CACHES (N),
      .XLEN       (XL),
      .TIMEOUT    (TO)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .req         (req),
      .req_cmd     (req_cmd),
      .req_addr    (req_addr),
      .bus_done    (bus_done),
      .gnt         (gnt),
      .bus_valid   (bus_valid),
      .bus_cmd     (bus_cmd),
      .bus_addr    (bus_addr),
      .bus_owner   (bus_owner),
      .timeout_err (timeout_err)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: rotating priority pointer plus the last broadcast values.
   int            m_ptr;
   bit            m_err;
   int            m_owner;
   logic [1:0]    m_cmd;
   logic [XL-1:0] m_addr;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_ptr   = 0;
      m_err   = 1'b0;
      m_owner = 0;
      m_cmd   = 2'd0;
      m_addr  = '0;
   endtask

   task automatic check_hold(input string tag, input logic [N-1:0] exp_gnt, input bit exp_valid);
      check({tag, "_gnt"},   64'(gnt),         64'(exp_gnt));
      check({tag, "_valid"}, 64'(bus_valid),   64'(exp_valid));
      check({tag, "_owner"}, 64'(bus_owner),   64'(m_owner));
      check({tag, "_cmd"},   64'(bus_cmd),     64'(m_cmd));
      check({tag, "_addr"},  64'(bus_addr),    64'(m_addr));
      check({tag, "_err"},   64'(timeout_err), 64'(m_err));
   endtask

   function automatic int pick(input logic [N-1:0] m, input int p);
      logic [N-1:0] t;
      for (int k = 0; k < N; k++) begin
         t = m >> ((p + k) % N);
         if (t[0]) return (p + k) % N;
      end
      return -1;
   endfunction

   function automatic logic noise(input int mode);
      if (mode == 2) return 1'b1;
      if (mode == 1) return 1'($urandom_range(0, 1));
      return 1'b0;
   endfunction

   // Starts and ends on a falling edge with the arbiter idle.
   // done_at: WAIT cycle carrying bus_done (0 = never); abort_at: WAIT cycle in which rst is pulsed.
   task automatic do_txn(input logic [N-1:0] mask, input logic [2*N-1:0] cmds,
                         input logic [XL*N-1:0] addrs, input int done_at,
                         input int done_mode, input int abort_at);
      int w;
      int n;
      logic [2*N-1:0]  tc;
      logic [XL*N-1:0] ta;
      check_hold("idle", '0, 1'b0);
      req      = mask;
      req_cmd  = cmds;
      req_addr = addrs;
      bus_done = noise(done_mode);
      w = pick(mask, m_ptr);
      if (w < 0) begin
         @(negedge clk);
         return;
      end
      tc      = cmds >> (2 * w);
      ta      = addrs >> (XL * w);
      m_owner = w;
      m_cmd   = tc[1:0];
      m_addr  = ta[XL-1:0];
      @(negedge clk);
      check_hold("bcast", N'(1) << w, m_cmd != 2'd3);
      req_cmd  = (2*N)'($urandom);
      req_addr = {$urandom, $urandom, $urandom, $urandom};
      req      = N'($urandom);
      bus_done = noise(done_mode);
      if (m_cmd < 2'd2) begin
         n = (done_at >= 1 && done_at <= TO) ? done_at : TO;
         for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            check_hold("wait", N'(1) << w, 1'b0);
            if (k == abort_at) begin
               #3 rst = 1'b1;
               req = 4'b1001;
               #1;
               model_reset();
               check_hold("async_rst", '0, 1'b0);
               @(negedge clk);
               rst = 1'b0;
               return;
            end
            bus_done = (k == done_at);
            req      = N'($urandom);
         end
         if (!(done_at >= 1 && done_at <= TO)) m_err = 1'b1;
      end
      @(negedge clk);
      check_hold("release", '0, 1'b0);
      bus_done = noise(done_mode);
      req      = '0;
      m_ptr    = (w + 1) % N;
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "bench timeout");
   end

   initial begin
      rst      = 1'b1;
      req      = '0;
      req_cmd  = '0;
      req_addr = '0;
      bus_done = 1'b0;
      model_reset();
      #1;
      check_hold("reset", '0, 1'b0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      // Single BusRd from cache 2, completion in third WAIT cycle.
      do_txn(4'b0100, 8'h00, {32'h0, 32'h40, 32'h0, 32'h0}, 3, 0, 0);

      // All four requesting after reset: 0,1,2,3.
      @(negedge clk); rst = 1'b1; @(negedge clk); rst = 1'b0; model_reset();
      for (int i = 0; i < 4; i++)
         do_txn(4'b1111, 8'h44, {$urandom, $urandom, $urandom, $urandom}, 1, 0, 0);

      // Wrap: cache 1, then 0 and 3 together (3 first), then 0.
      do_txn(4'b0010, 8'h00, {32'h33, 32'h22, 32'h11, 32'h00}, 2, 1, 0);
      do_txn(4'b1001, 8'h41, {32'h33, 32'h22, 32'h11, 32'h00}, 1, 1, 0);
      do_txn(4'b1001, 8'h41, {32'h33, 32'h22, 32'h11, 32'h00}, 1, 1, 0);

      // BusUpgr with bus_done held high, then reserved cmd.
      do_txn(4'b0010, 8'b0000_1000, {32'h0, 32'h0, 32'h1234, 32'h0}, 1, 2, 0);
      do_txn(4'b0010, 8'b0000_1100, {32'h0, 32'h0, 32'h5678, 32'h0}, 1, 2, 0);

      // Re-grant of a lone continuous requester.
      do_txn(4'b0100, 8'h00, {32'h0, 32'h80, 32'h0, 32'h0}, 1, 0, 0);
      do_txn(4'b0100, 8'h10, {32'h0, 32'h84, 32'h0, 32'h0}, 2, 0, 0);

      // bus_done on the last permitted WAIT cycle wins over the watchdog.
      do_txn(4'b0001, 8'h01, {32'h0, 32'h0, 32'h0, 32'hA0}, TO, 0, 0);

      // Timeout on BusRdX from cache 0, then a normal transaction from cache 1.
      do_txn(4'b0001, 8'h01, {32'h0, 32'h0, 32'h0, 32'hB0}, 0, 0, 0);
      do_txn(4'b0010, 8'h00, {32'h0, 32'h0, 32'hC0, 32'h0}, 2, 0, 0);

      // Reset mid-WAIT, then caches 0 and 3 request.
      do_txn(4'b0100, 8'h00, {32'h0, 32'hD0, 32'h0, 32'h0}, 0, 0, 2);
      do_txn(4'b1001, 8'h00, {32'hE3, 32'h0, 32'h0, 32'hE0}, 1, 0, 0);

      for (int i = 0; i < 150; i++)
         do_txn(N'($urandom_range(0, 15)), 8'($urandom),
                {$urandom, $urandom, $urandom, $urandom},
                $urandom_range(0, TO), 1, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Round-robin arbiter and sequencer for the shared snooping coherence bus in the MESI system. It sits between the per-core L1 cache controllers and the bus. Each cycle it selects one requesting cache and broadcasts that cache's coherence command and address to all snoopers for one cycle. It then holds ownership until the responder (memory or a supplying cache) signals completion, and releases the bus. A watchdog flags transactions that never complete.

## Interface
- `NUM_CACHES`, default 4: number of requesting caches; must be ≥2.
- `XLEN`, default 32: address width.
- `TIMEOUT`, default 64: maximum number of cycles spent in WAIT before the transaction is abandoned; must be ≥2.
- `clk` in 1: single clock; all state changes on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req` in NUM_CACHES: `req[i]` high means cache i requests the bus.
- `req_cmd` in 2*NUM_CACHES: command for cache i at `[2i+1:2i]`. Encoding: 0 = BusRd, 1 = BusRdX, 2 = BusUpgr, 3 = reserved.
- `req_addr` in XLEN*NUM_CACHES: address for cache i at `[XLEN*i +: XLEN]`.
- `bus_done` in 1: completion pulse from the responder; sampled only in WAIT.
- `gnt` out NUM_CACHES: one-hot ownership grant.
- `bus_valid` out 1: snoop broadcast strobe.
- `bus_cmd` out 2: broadcast command.
- `bus_addr` out XLEN: broadcast address.
- `bus_owner` out $clog2(NUM_CACHES): index of the current owner.
- `timeout_err` out 1: sticky watchdog flag.

## Operation
- **IDLE**
  - If any `req` bit is high, select the first set bit scanning upward from `ptr`, wrapping around.
  - Capture that cache's index, `req_cmd` and `req_addr` into registers, then go to BCAST.
  - If no `req` bit is high, stay in IDLE.
- **BCAST** (exactly 1 cycle)
  - `bus_valid` = 1, except for cmd 3, where `bus_valid` = 0.
  - Next state: WAIT for BusRd or BusRdX; RELEASE for BusUpgr or cmd 3, since these move no data.
- **WAIT**
  - Watchdog counter `wcnt` is cleared on entry.
  - `bus_done` = 1 → RELEASE.
  - Otherwise `wcnt` increments. If `wcnt == TIMEOUT-1`, set `timeout_err` and go to RELEASE.
- **RELEASE** (exactly 1 cycle)
  - `gnt` = 0.
  - `ptr` ← (owner + 1) mod NUM_CACHES.
  - Next state: IDLE.
- **Grant**
  - `gnt[owner]` = 1 in BCAST and WAIT; 0 in all other states.
  - `bus_owner`, `bus_cmd` and `bus_addr` show the captured values in BCAST, WAIT and RELEASE. They hold their last values in IDLE.
- **Captured values**
  - Command and address are frozen at selection. Changes on `req_cmd` or `req_addr` after selection are ignored.
- **Requester rule**
  - A requester drops `req` within the RELEASE cycle if it has no further transaction.
  - A `req` still high in the following IDLE cycle is treated as a new request.
- **Ignored inputs**
  - `bus_done` outside WAIT is ignored.
  - `req` is ignored outside IDLE.
- **Sticky error**
  - `timeout_err` clears only on `rst`. Arbitration continues normally after a timeout.
- **Output decode**
  - All outputs are decoded from registered state only; there is no combinational path from inputs to outputs.

## Timing
- **Reset**
  - `rst` = 1 immediately, without a clock edge, sets: state IDLE, `ptr` = 0, `wcnt` = 0.
  - Output reset values: `gnt` = 0, `bus_valid` = 0, `bus_cmd` = 0, `bus_addr` = 0, `bus_owner` = 0, `timeout_err` = 0.
  - Reset mid-transaction abandons the transaction; no RELEASE cycle occurs.
- **Latency**
  - `req` sampled high in IDLE at edge E → `gnt` and `bus_valid` high in the cycle after E.
- **Transaction length**
  - BusRd/BusRdX: IDLE 1 + BCAST 1 + WAIT n≥1 + RELEASE 1, so 3+n cycles.
  - BusUpgr: 3 cycles.
  - Minimum BusRd/BusRdX: 4 cycles, with `bus_done` in the first WAIT cycle.
- **Watchdog**
  - WAIT lasts at most TIMEOUT cycles.
  - `bus_done` in the same cycle as the timeout condition: done wins and `timeout_err` is not set.
  - `timeout_err` rises in the RELEASE cycle of the timed-out transaction.
- **Priority and fairness**
  - After reset, cache 0 has highest priority.
  - Back-to-back requests from the same cache, with no other requesters, are re-granted with one IDLE gap.
  - With all caches requesting continuously, a cache waits at most NUM_CACHES-1 transactions.

## Test plan
- **Single BusRd:** after reset, `req[2]`=1, cmd 0, addr 0x40; `bus_done` on the 3rd WAIT cycle → one cycle later `gnt`=0100 and `bus_valid`=1 for 1 cycle with `bus_cmd`=0, `bus_addr`=0x40, `bus_owner`=2. `gnt` stays 0100 through WAIT, is 0 in RELEASE, and the transaction totals 6 cycles.
- **All four request after reset, each `bus_done` in its first WAIT cycle:** grants in order 0,1,2,3, one every 4 cycles, and `gnt` is never multi-hot.
- **Round-robin wrap:** cache 1 completes, then caches 0 and 3 request together → cache 3 is granted first, then cache 0.
- **BusUpgr from cache 1, `bus_done` held high throughout:** sequence BCAST→RELEASE→IDLE with `bus_valid` for 1 cycle. The 3-cycle transaction has no WAIT state, `bus_done` has no effect, and cmd 3 produces a grant with `bus_valid`=0.
- **Timeout, TIMEOUT=8, BusRdX from cache 0, no `bus_done`:** 8 WAIT cycles, then `timeout_err`=1 and `gnt`=0. A following request from cache 1 completes normally while `timeout_err` stays 1.
- **Reset mid-WAIT:** assert `rst` between clock edges → `gnt`, `bus_valid` and `timeout_err` go to 0 immediately. After reset release with caches 0 and 3 requesting, cache 0 is granted first.
